multicycle_core: RTL and testbench

//  Parametrised multi-cycle processor core: fetch/decode/execute FSM, internal register file, inline ALU.

---
 rtl/mcore_pkg.sv | 44 ++++
 rtl/mcore_regfile.sv | 36 +++
 rtl/multicycle_core.sv | 168 ++++++++++++++++
 tb/tb_multicycle_core.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcore_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, special sub-ops, FSM states
// and instruction field extraction helpers.
package mcore_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_LD  = 3'd4,
        OP_ST  = 3'd5,
        OP_BZ  = 3'd6,
        OP_SPC = 3'd7
    } op_e;

    localparam logic [2:0] SPC_HALT = 3'd0;
    localparam logic [2:0] SPC_INC  = 3'd1;
    localparam logic [2:0] SPC_DEC  = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_e;

    // Helpers take the instruction zero-extended to 32 bits so one definition serves any RW
    localparam int IR_MAX_W = 32;

    function automatic op_e fieldOp(input logic [IR_MAX_W-1:0] ir, input int rw);
        return op_e'(ir[2*rw +: 3]);
    endfunction

    function automatic logic [IR_MAX_W-1:0] fieldRd(input logic [IR_MAX_W-1:0] ir, input int rw);
        return (ir >> rw) & ((IR_MAX_W'(1) << rw) - IR_MAX_W'(1));
    endfunction

    function automatic logic [IR_MAX_W-1:0] fieldRs(input logic [IR_MAX_W-1:0] ir, input int rw);
        return ir & ((IR_MAX_W'(1) << rw) - IR_MAX_W'(1));
    endfunction

endpackage

// File: rtl/mcore_regfile.sv
// Register file for the multi-cycle core: two asynchronous read ports, one synchronous
// write port, all registers cleared by synchronous reset.
module mcore_regfile
    import mcore_pkg::*;
#(
    parameter int DW = 8,
    parameter int NREG = 8,
    localparam int RW = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [RW-1:0] raddrA_i,
    input  logic [RW-1:0] raddrB_i,
    output logic [DW-1:0] rdataA_o,
    output logic [DW-1:0] rdataB_o,
    input  logic          we_i,
    input  logic [RW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdataA_o = regs_q[raddrA_i];
    assign rdataB_o = regs_q[raddrB_i];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core: FETCH/DECODE/EXEC(/MEM) FSM with inline ALU and next-PC logic.
// Optional performance counters are enabled by defining MCORE_PERF_CNT_EN.
module multicycle_core
    import mcore_pkg::*;
#(
    parameter int DW = 8,
    parameter int NREG = 8,
    parameter int PCW = 8,
    localparam int RW = $clog2(NREG),
    localparam int IW = 3 + 2 * RW
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    output logic [PCW-1:0] imem_addr_o,
    input  logic [IW-1:0]  imem_data_i,
    output logic           dmem_req_o,
    output logic           dmem_we_o,
    output logic [DW-1:0]  dmem_addr_o,
    output logic [DW-1:0]  dmem_wdata_o,
    input  logic [DW-1:0]  dmem_rdata_i,
    input  logic           dmem_ack_i,
    output logic           busy_o,
    output logic           halt_o
`ifdef MCORE_PERF_CNT_EN
    ,
    output logic [31:0]    cycle_cnt_o,
    output logic [31:0]    retired_cnt_o
`endif
);

    state_e         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [IW-1:0]  ir_q, ir_d;

    logic [IR_MAX_W-1:0] irWide;
    op_e                 op;
    logic [RW-1:0]       rdIdx, rsIdx;
    logic [DW-1:0]       rdVal, rsVal;
    logic                regWe;
    logic [DW-1:0]       regWdata;

    assign irWide = IR_MAX_W'(ir_q);
    assign op     = fieldOp(irWide, RW);
    assign rdIdx  = RW'(fieldRd(irWide, RW));
    assign rsIdx  = RW'(fieldRs(irWide, RW));

    mcore_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .raddrA_i (rdIdx),
        .raddrB_i (rsIdx),
        .rdataA_o (rdVal),
        .rdataB_o (rsVal),
        .we_i     (regWe),
        .waddr_i  (rdIdx),
        .wdata_i  (regWdata)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        regWe    = 1'b0;
        regWdata = '0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = imem_data_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PCW'(1);
                case (op)
                    OP_ADD: begin regWe = 1'b1; regWdata = rdVal + rsVal; end
                    OP_SUB: begin regWe = 1'b1; regWdata = rdVal - rsVal; end
                    OP_AND: begin regWe = 1'b1; regWdata = rdVal & rsVal; end
                    OP_XOR: begin regWe = 1'b1; regWdata = rdVal ^ rsVal; end
                    // Memory ops hold the PC until the access completes
                    OP_LD, OP_ST: begin
                        state_d = S_MEM;
                        pc_d    = pc_q;
                    end
                    OP_BZ: begin
                        if (rdVal == '0) begin
                            pc_d = pc_q + PCW'(signed'(rsIdx));
                        end
                    end
                    default: begin
                        case (rsIdx)
                            RW'(SPC_HALT): state_d = S_HALTED;
                            RW'(SPC_INC): begin regWe = 1'b1; regWdata = rdVal + DW'(1); end
                            RW'(SPC_DEC): begin regWe = 1'b1; regWdata = rdVal - DW'(1); end
                            default: ;
                        endcase
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack_i) begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + PCW'(1);
                    if (op == OP_LD) begin
                        regWe    = 1'b1;
                        regWdata = dmem_rdata_i;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr_o  = pc_q;
    assign dmem_req_o   = (state_q == S_MEM);
    assign dmem_we_o    = dmem_req_o && (op == OP_ST);
    assign dmem_addr_o  = dmem_req_o ? rsVal : '0;
    assign dmem_wdata_o = dmem_req_o ? rdVal : '0;
    assign busy_o       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                          (state_q == S_EXEC) || (state_q == S_MEM);
    assign halt_o       = (state_q == S_HALTED);

`ifdef MCORE_PERF_CNT_EN
    logic [31:0] cycleCnt_q, retiredCnt_q;
    logic        retire, startAccept;

    // An instruction retires at the end of EXEC, or at its ACK for memory ops
    assign retire      = ((state_q == S_EXEC) && (op != OP_LD) && (op != OP_ST)) ||
                         ((state_q == S_MEM) && dmem_ack_i);
    assign startAccept = start_i && ((state_q == S_IDLE) || (state_q == S_HALTED));

    always_ff @(posedge clk_i) begin
        if (reset_i || startAccept) begin
            cycleCnt_q   <= '0;
            retiredCnt_q <= '0;
        end else begin
            if (busy_o && (cycleCnt_q != '1)) begin
                cycleCnt_q <= cycleCnt_q + 32'd1;
            end
            if (retire && (retiredCnt_q != '1)) begin
                retiredCnt_q <= retiredCnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt_o   = cycleCnt_q;
    assign retired_cnt_o = retiredCnt_q;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: instruction ROM and handshaked data memory
// models, plus an instruction-level reference model of the ISA.
module tb_multicycle_core;

    localparam int DW = 8;
    localparam int NREG = 8;
    localparam int PCW = 8;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [PCW-1:0] imemAddr;
    logic [IW-1:0]  imemData = '0;
    logic          dmemReq, dmemWe;
    logic [DW-1:0] dmemAddr, dmemWdata;
    logic [DW-1:0] dmemRdata = '0;
    logic          dmemAck = 1'b0;
    logic          busy, halt;
`ifdef MCORE_PERF_CNT_EN
    logic [31:0]   cycleCnt, retiredCnt;
`endif

    int checks = 0;
    int passes = 0;

    logic [IW-1:0] rom [256];
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mMem [256];
    logic [DW-1:0] mReg [NREG];
    int stWait = 0;
    int ldWait = 0;

    // Access log filled by the data memory responder
    int          accCount = 0;
    logic        accWe [64];
    logic [7:0]  accAddr [64];
    logic [7:0]  accWdata [64];
    int          accCycles [64];
    bit          accStable [64];
    bit          accDropped [64];

    always #5 clk = ~clk;

    multicycle_core #(.DW(DW), .NREG(NREG), .PCW(PCW)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .imem_addr_o  (imemAddr),
        .imem_data_i  (imemData),
        .dmem_req_o   (dmemReq),
        .dmem_we_o    (dmemWe),
        .dmem_addr_o  (dmemAddr),
        .dmem_wdata_o (dmemWdata),
        .dmem_rdata_i (dmemRdata),
        .dmem_ack_i   (dmemAck),
        .busy_o       (busy),
        .halt_o       (halt)
`ifdef MCORE_PERF_CNT_EN
        ,
        .cycle_cnt_o   (cycleCnt),
        .retired_cnt_o (retiredCnt)
`endif
    );

    // Sync-read instruction ROM
    always @(posedge clk) imemData <= rom[imemAddr];

    // Data memory responder: acks after the configured number of wait cycles
    int   reqCnt = 0;
    bit   ackedPrev = 0;
    logic curWe;
    logic [7:0] curAddr, curWdata;
    bit   curStable;
    always @(negedge clk) begin
        if (reset) begin
            reqCnt = 0;
            dmemAck = 1'b0;
            ackedPrev = 0;
        end else begin
            if (ackedPrev) begin
                accDropped[accCount-1] = !dmemReq;
                ackedPrev = 0;
            end
            if (dmemReq) begin
                if (reqCnt == 0) begin
                    curWe = dmemWe; curAddr = dmemAddr; curWdata = dmemWdata; curStable = 1;
                end else if (curWe !== dmemWe || curAddr !== dmemAddr || curWdata !== dmemWdata) begin
                    curStable = 0;
                end
                reqCnt++;
                if (reqCnt > (dmemWe ? stWait : ldWait)) begin
                    dmemAck = 1'b1;
                    dmemRdata = mem[dmemAddr];
                    if (dmemWe) mem[dmemAddr] = dmemWdata;
                    if (accCount < 64) begin
                        accWe[accCount] = curWe; accAddr[accCount] = curAddr;
                        accWdata[accCount] = curWdata; accCycles[accCount] = reqCnt;
                        accStable[accCount] = curStable; accDropped[accCount] = 0;
                        accCount++;
                        ackedPrev = 1;
                    end
                    reqCnt = 0;
                end else begin
                    dmemAck = 1'b0;
                end
            end else begin
                dmemAck = 1'b0;
                reqCnt = 0;
            end
        end
    end

    function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs);
        return {op[2:0], rd[2:0], rs[2:0]};
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = enc(7, 0, 0);
    endtask

    task automatic doReset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < NREG; i++) mReg[i] = '0;
    endtask

    // ISA-level reference: executes the ROM from PC 0 until HALT
    task automatic modelRun(output int cycles, output int retired);
        logic [7:0] pc;
        logic [2:0] op, rd, rs;
        pc = 0; cycles = 0; retired = 0;
        for (int guard = 0; guard < 2000; guard++) begin
            {op, rd, rs} = rom[pc];
            retired++;
            case (op)
                3'd0: begin mReg[rd] = mReg[rd] + mReg[rs]; cycles += 3; pc = pc + 1; end
                3'd1: begin mReg[rd] = mReg[rd] - mReg[rs]; cycles += 3; pc = pc + 1; end
                3'd2: begin mReg[rd] = mReg[rd] & mReg[rs]; cycles += 3; pc = pc + 1; end
                3'd3: begin mReg[rd] = mReg[rd] ^ mReg[rs]; cycles += 3; pc = pc + 1; end
                3'd4: begin mReg[rd] = mMem[mReg[rs]]; cycles += 4 + ldWait; pc = pc + 1; end
                3'd5: begin mMem[mReg[rs]] = mReg[rd]; cycles += 4 + stWait; pc = pc + 1; end
                3'd6: begin
                    cycles += 3;
                    if (mReg[rd] == 0) pc = pc + {{5{rs[2]}}, rs};
                    else pc = pc + 1;
                end
                default: begin
                    cycles += 3;
                    if (rs == 0) return;
                    if (rs == 1) mReg[rd] = mReg[rd] + 1;
                    if (rs == 2) mReg[rd] = mReg[rd] - 1;
                    pc = pc + 1;
                end
            endcase
        end
    endtask

    // Pulses START and counts BUSY cycles until HALT, bounded
    task automatic runProgram(output int cycles, output bit timedOut);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cycles = 0;
        timedOut = 0;
        while (!halt) begin
            if (busy) cycles++;
            if (cycles > 3000) begin timedOut = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic waitAddr(input logic [7:0] target, output bit found);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (busy && imemAddr == target) found = 1;
        end
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passes++;
        checks++; if (halt !== 1'b0) $display("[TB] FAIL reset_halt got %b want 0", halt); else passes++;
        checks++; if (imemAddr !== 8'h00) $display("[TB] FAIL reset_imem_addr got %h want 00", imemAddr); else passes++;
        checks++;
        if ({dmemReq, dmemWe, dmemAddr, dmemWdata} !== 18'h0)
            $display("[TB] FAIL reset_dmem got req=%b we=%b addr=%h wdata=%h want all 0", dmemReq, dmemWe, dmemAddr, dmemWdata);
        else passes++;
        for (int i = 0; i < NREG; i++) begin
            checks++;
            if (dut.u_regfile.regs_q[i] !== 8'h00) $display("[TB] FAIL reset_reg%0d got %h want 00", i, dut.u_regfile.regs_q[i]);
            else passes++;
        end
    endtask

    task automatic test_add_inc();
        int mc, mr, cyc; bit to;
        doReset();
        clearRom();
        for (int i = 0; i < 3; i++) rom[i] = enc(7, 1, 1);
        rom[3] = enc(0, 1, 1);
        modelRun(mc, mr);
        runProgram(cyc, to);
        checks++; if (to) $display("[TB] FAIL add_timeout got timeout want halt"); else passes++;
        checks++; if (dut.u_regfile.regs_q[1] !== 8'd6) $display("[TB] FAIL add_r1 got %0d want 6", dut.u_regfile.regs_q[1]); else passes++;
        checks++; if (halt !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL add_status got halt=%b busy=%b want 1/0", halt, busy); else passes++;
        checks++; if (cyc != mc) $display("[TB] FAIL add_cycles got %0d want %0d", cyc, mc); else passes++;
    endtask

    task automatic test_sub_xor();
        int mc, mr, cyc; bit to;
        doReset();
        clearRom();
        rom[0] = enc(7, 3, 1);
        rom[1] = enc(1, 2, 3);
        modelRun(mc, mr);
        runProgram(cyc, to);
        checks++; if (to || dut.u_regfile.regs_q[2] !== 8'hFF) $display("[TB] FAIL sub_r2 got %h want ff", dut.u_regfile.regs_q[2]); else passes++;
        clearRom();
        rom[0] = enc(3, 2, 2);
        modelRun(mc, mr);
        runProgram(cyc, to);
        checks++; if (to || dut.u_regfile.regs_q[2] !== 8'h00) $display("[TB] FAIL xor_r2 got %h want 00", dut.u_regfile.regs_q[2]); else passes++;
        checks++; if (dut.u_regfile.regs_q[3] !== mReg[3]) $display("[TB] FAIL xor_r3_kept got %h want %h", dut.u_regfile.regs_q[3], mReg[3]); else passes++;
    endtask

    task automatic test_branch();
        bit found;
        int cyc;
        // Taken backwards branch: BZ r0,-2 at PC 5
        doReset();
        clearRom();
        for (int i = 0; i < 5; i++) rom[i] = enc(7, 0, 3);
        rom[5] = enc(6, 0, 6);
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        waitAddr(8'd5, found);
        repeat (3) @(negedge clk);
        checks++; if (!found || imemAddr !== 8'd3) $display("[TB] FAIL bz_taken got %0d want 3", imemAddr); else passes++;
        // Not-taken branch with r0=1
        doReset();
        rom[0] = enc(7, 0, 1);
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        waitAddr(8'd5, found);
        repeat (3) @(negedge clk);
        checks++; if (!found || imemAddr !== 8'd6) $display("[TB] FAIL bz_not_taken got %0d want 6", imemAddr); else passes++;
        cyc = 0;
        while (!halt && cyc < 100) begin @(negedge clk); cyc++; end
        checks++; if (halt !== 1'b1) $display("[TB] FAIL bz_halt got %b want 1", halt); else passes++;
        // PC wrap in both directions
        doReset();
        clearRom();
        rom[0] = enc(6, 0, 7);
        rom[255] = enc(6, 0, 1);
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        waitAddr(8'd255, found);
        checks++; if (!found) $display("[TB] FAIL bz_wrap_back got %0d want 255", imemAddr); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (imemAddr !== 8'd0) $display("[TB] FAIL bz_wrap_fwd got %0d want 0", imemAddr); else passes++;
        doReset();
    endtask

    task automatic test_mem();
        int mc, mr, cyc; bit to;
        logic [7:0] val;
        doReset();
        val = 8'($urandom_range(1, 255));
        mem[0] = val; mMem[0] = val;
        clearRom();
        rom[0] = enc(4, 4, 0);
        rom[1] = enc(7, 5, 1);
        for (int i = 2; i < 6; i++) rom[i] = enc(0, 5, 5);
        rom[6] = enc(5, 4, 5);
        rom[7] = enc(4, 6, 5);
        accCount = 0;
        // ST waits 3 cycles, both loads ack immediately
        stWait = 3; ldWait = 0;
        modelRun(mc, mr);
        runProgram(cyc, to);
        checks++; if (to || accCount != 3) $display("[TB] FAIL mem_access_count got %0d want 3", accCount); else passes++;
        checks++;
        if (accWe[1] !== 1'b1 || accAddr[1] !== 8'h10 || accWdata[1] !== val)
            $display("[TB] FAIL st_fields got we=%b addr=%h wdata=%h want 1/10/%h", accWe[1], accAddr[1], accWdata[1], val);
        else passes++;
        checks++; if (accCycles[1] != 4) $display("[TB] FAIL st_req_len got %0d want 4", accCycles[1]); else passes++;
        checks++; if (!accStable[1] || !accDropped[1]) $display("[TB] FAIL st_handshake got stable=%0d dropped=%0d want 1/1", accStable[1], accDropped[1]); else passes++;
        checks++; if (accWe[2] !== 1'b0 || accCycles[2] != 1 || !accDropped[2]) $display("[TB] FAIL ld_handshake got we=%b len=%0d dropped=%0d want 0/1/1", accWe[2], accCycles[2], accDropped[2]); else passes++;
        checks++; if (dut.u_regfile.regs_q[6] !== val) $display("[TB] FAIL ld_r6 got %h want %h", dut.u_regfile.regs_q[6], val); else passes++;
        checks++; if (cyc != mc) $display("[TB] FAIL mem_cycles got %0d want %0d", cyc, mc); else passes++;
    endtask

    task automatic test_reset_in_mem();
        int cyc;
        doReset();
        clearRom();
        rom[0] = enc(7, 1, 1);
        rom[1] = enc(4, 2, 1);
        ldWait = 1000;
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!dmemReq && cyc < 50) begin @(negedge clk); cyc++; end
        checks++; if (dmemReq !== 1'b1) $display("[TB] FAIL rmem_req_seen got %b want 1", dmemReq); else passes++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dmemReq !== 1'b0 || busy !== 1'b0 || halt !== 1'b0) $display("[TB] FAIL rmem_state got req=%b busy=%b halt=%b want 0/0/0", dmemReq, busy, halt); else passes++;
        checks++; if (dut.u_regfile.regs_q[1] !== 8'h00 || dut.u_regfile.regs_q[2] !== 8'h00) $display("[TB] FAIL rmem_regs got %h/%h want 00/00", dut.u_regfile.regs_q[1], dut.u_regfile.regs_q[2]); else passes++;
        reset = 1'b0;
        ldWait = 0;
        for (int i = 0; i < NREG; i++) mReg[i] = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rmem_idle got busy=%b want 0", busy); else passes++;
    endtask

    task automatic test_start_ignored();
        int mc, mr, cyc;
        doReset();
        clearRom();
        rom[0] = enc(7, 1, 1);
        rom[1] = enc(7, 1, 1);
        modelRun(mc, mr);
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!halt && cyc < 200) begin
            if (busy) cyc++;
            start = (cyc == 3);
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (dut.u_regfile.regs_q[1] !== mReg[1]) $display("[TB] FAIL start_ign_r1 got %h want %h", dut.u_regfile.regs_q[1], mReg[1]); else passes++;
        checks++; if (cyc != mc) $display("[TB] FAIL start_ign_cycles got %0d want %0d", cyc, mc); else passes++;
    endtask

    task automatic test_random();
        int mc, mr, cyc, len, k, bad; bit to;
        for (int it = 0; it < 20; it++) begin
            clearRom();
            len = $urandom_range(1, 12);
            for (int p = 0; p < len; p++) begin
                k = $urandom_range(0, 8);
                if (k <= 5) rom[p] = enc(k, $urandom_range(0, 7), $urandom_range(0, 7));
                else if (k == 6) rom[p] = enc(7, $urandom_range(0, 7), 1);
                else if (k == 7) rom[p] = enc(7, $urandom_range(0, 7), 2);
                else rom[p] = enc(7, $urandom_range(0, 7), $urandom_range(3, 7));
            end
            stWait = $urandom_range(0, 3);
            ldWait = $urandom_range(0, 3);
            modelRun(mc, mr);
            runProgram(cyc, to);
            bad = 0;
            for (int i = 0; i < NREG; i++) if (dut.u_regfile.regs_q[i] !== mReg[i]) bad++;
            checks++; if (to || bad != 0) $display("[TB] FAIL rand%0d_regs got %0d differing regs want 0", it, bad); else passes++;
            checks++; if (cyc != mc) $display("[TB] FAIL rand%0d_cycles got %0d want %0d", it, cyc, mc); else passes++;
            bad = 0;
            for (int a = 0; a < 256; a++) if (mem[a] !== mMem[a]) bad++;
            checks++; if (bad != 0) $display("[TB] FAIL rand%0d_mem got %0d differing bytes want 0", it, bad); else passes++;
        end
        stWait = 0; ldWait = 0;
    endtask

`ifdef MCORE_PERF_CNT_EN
    task automatic test_perf();
        int mc, mr, cyc; bit to;
        doReset();
        clearRom();
        rom[0] = enc(0, 1, 2);
        rom[1] = enc(1, 3, 4);
        rom[2] = enc(3, 5, 6);
        modelRun(mc, mr);
        runProgram(cyc, to);
        checks++; if (retiredCnt !== 32'(mr)) $display("[TB] FAIL perf_retired got %0d want %0d", retiredCnt, mr); else passes++;
        checks++; if (cycleCnt !== 32'(mc)) $display("[TB] FAIL perf_cycles got %0d want %0d", cycleCnt, mc); else passes++;
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        checks++; if (cycleCnt !== 32'd0 || retiredCnt !== 32'd0) $display("[TB] FAIL perf_clear got %0d/%0d want 0/0", cycleCnt, retiredCnt); else passes++;
        runProgram(cyc, to);
    endtask
`endif

    initial begin
        clearRom();
        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'($urandom);
            mMem[a] = mem[a];
        end
        for (int i = 0; i < NREG; i++) mReg[i] = '0;
        test_reset();
        test_add_inc();
        test_sub_xor();
        test_branch();
        test_mem();
        test_reset_in_mem();
        test_start_ignored();
        test_random();
`ifdef MCORE_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
